// File: rtl/io_command_queue.sv
// io_command_queue
//   Command queue between a core and an IO device. The core pushes 21-bit
//   entries {ResponseRequested, DestReg[3:0], Data[15:0]} with a REQ/ACK
//   handshake. The head entry is presented to the device combinationally.
//   When the device accepts the head and flags a register writeback in that
//   same cycle, the writeback is registered and returned to the core as a
//   one-cycle pulse.
//
// Ports
//   clk, clk_en, sync_rst          : clock, clock enable, sync active-high reset
//   Core_REQ / Core_ACK            : push handshake (ACK = clk_en && !full)
//   Core_ResponseRequested,
//   Core_DestReg, Core_Data        : entry fields written on push
//   IO_REQ / IO_CommandEn / IO_ACK : head-valid toward device, device ready
//   IO_ResponseRequested,
//   IO_DestRegOut, IO_DataOut      : head entry fields (don't-care when empty)
//   Dev_RegResponseFlag,
//   Dev_DestReg, Dev_Data          : device writeback, sampled on a pop
//   Resp_Valid, Resp_DestReg,
//   Resp_Data                      : registered writeback to the core
//   Occupancy                      : number of stored entries
module io_command_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clk_en,
    input  logic                     sync_rst,
    input  logic                     Core_REQ,
    output logic                     Core_ACK,
    input  logic                     Core_ResponseRequested,
    input  logic [3:0]               Core_DestReg,
    input  logic [15:0]              Core_Data,
    output logic                     IO_REQ,
    input  logic                     IO_ACK,
    output logic                     IO_CommandEn,
    output logic                     IO_ResponseRequested,
    output logic [3:0]               IO_DestRegOut,
    output logic [15:0]              IO_DataOut,
    input  logic                     Dev_RegResponseFlag,
    input  logic [3:0]               Dev_DestReg,
    input  logic [15:0]              Dev_Data,
    output logic                     Resp_Valid,
    output logic [3:0]               Resp_DestReg,
    output logic [15:0]              Resp_Data,
    output logic [$clog2(DEPTH):0]   Occupancy
);

    localparam int PtrW = $clog2(DEPTH);
    localparam int CntW = PtrW + 1;

    logic [20:0]     entryMem [DEPTH];
    logic [PtrW-1:0] rdPtr;
    logic [PtrW-1:0] wrPtr;
    logic [CntW-1:0] count;
    logic            isFull;
    logic            isEmpty;
    logic            push;
    logic            pop;
    logic [20:0]     headEntry;

    // Full/empty come from the counter only; pointers are equal in both cases.
    assign isFull   = (count == CntW'(DEPTH));
    assign isEmpty  = (count == '0);
    assign Core_ACK = clk_en && !isFull;
    assign push     = Core_REQ && Core_ACK;
    assign IO_REQ   = !isEmpty;
    assign IO_CommandEn = IO_REQ;
    assign pop      = IO_REQ && IO_ACK && clk_en;

    assign headEntry            = entryMem[rdPtr];
    assign IO_ResponseRequested = headEntry[20];
    assign IO_DestRegOut        = headEntry[19:16];
    assign IO_DataOut           = headEntry[15:0];
    assign Occupancy            = count;

    // Storage has no reset; a write during the reset cycle is harmless since
    // the pointers and count are cleared, but it is suppressed anyway.
    always_ff @(posedge clk) begin
        if (push && !sync_rst) begin
            entryMem[wrPtr] <= {Core_ResponseRequested, Core_DestReg, Core_Data};
        end
    end

    // DEPTH is a power of two, so pointers wrap modulo DEPTH naturally.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (clk_en) begin
            if (push) begin
                wrPtr <= wrPtr + PtrW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // Writeback is only honoured on the cycle the head is actually taken.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            Resp_Valid   <= 1'b0;
            Resp_DestReg <= '0;
            Resp_Data    <= '0;
        end else if (clk_en) begin
            Resp_Valid <= pop && Dev_RegResponseFlag;
            if (pop && Dev_RegResponseFlag) begin
                Resp_DestReg <= Dev_DestReg;
                Resp_Data    <= Dev_Data;
            end
        end
    end

endmodule

// File: tb/tb_io_command_queue.sv
// tb_io_command_queue
//   Directed bench for io_command_queue at DEPTH=4. Inputs change 1 time unit
//   after a rising edge; outputs are checked 1 unit later, well before the
//   next edge.
module tb_io_command_queue;

    logic        clk = 1'b0;
    logic        clk_en;
    logic        sync_rst;
    logic        Core_REQ;
    logic        Core_ACK;
    logic        Core_ResponseRequested;
    logic [3:0]  Core_DestReg;
    logic [15:0] Core_Data;
    logic        IO_REQ;
    logic        IO_ACK;
    logic        IO_CommandEn;
    logic        IO_ResponseRequested;
    logic [3:0]  IO_DestRegOut;
    logic [15:0] IO_DataOut;
    logic        Dev_RegResponseFlag;
    logic [3:0]  Dev_DestReg;
    logic [15:0] Dev_Data;
    logic        Resp_Valid;
    logic [3:0]  Resp_DestReg;
    logic [15:0] Resp_Data;
    logic [2:0]  Occupancy;

    int nCompared   = 0;
    int nMismatched = 0;

    io_command_queue #(.DEPTH(4)) dut (
        .clk                    (clk),
        .clk_en                 (clk_en),
        .sync_rst               (sync_rst),
        .Core_REQ               (Core_REQ),
        .Core_ACK               (Core_ACK),
        .Core_ResponseRequested (Core_ResponseRequested),
        .Core_DestReg           (Core_DestReg),
        .Core_Data              (Core_Data),
        .IO_REQ                 (IO_REQ),
        .IO_ACK                 (IO_ACK),
        .IO_CommandEn           (IO_CommandEn),
        .IO_ResponseRequested   (IO_ResponseRequested),
        .IO_DestRegOut          (IO_DestRegOut),
        .IO_DataOut             (IO_DataOut),
        .Dev_RegResponseFlag    (Dev_RegResponseFlag),
        .Dev_DestReg            (Dev_DestReg),
        .Dev_Data               (Dev_Data),
        .Resp_Valid             (Resp_Valid),
        .Resp_DestReg           (Resp_DestReg),
        .Resp_Data              (Resp_Data),
        .Occupancy              (Occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        Core_REQ = 1'b0;
        Core_ResponseRequested = 1'b0;
        Core_DestReg = 4'h0;
        Core_Data = 16'h0000;
        IO_ACK = 1'b0;
        Dev_RegResponseFlag = 1'b0;
        Dev_DestReg = 4'h0;
        Dev_Data = 16'h0000;
    endtask

    task automatic test_reset();
        idleInputs();
        clk_en = 1'b1;
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        #1;
        nCompared++;
        if (Occupancy !== 3'd0) begin
            nMismatched++;
            $display("FAIL reset_occ: got %0d want 0", Occupancy);
        end
        nCompared++;
        if (IO_REQ !== 1'b0 || IO_CommandEn !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_ioreq: got %b/%b want 0/0", IO_REQ, IO_CommandEn);
        end
        nCompared++;
        if (Resp_Valid !== 1'b0 || Resp_DestReg !== 4'h0 || Resp_Data !== 16'h0000) begin
            nMismatched++;
            $display("FAIL reset_resp: got %b %h %h want 0 0 0000", Resp_Valid, Resp_DestReg, Resp_Data);
        end
        nCompared++;
        if (Core_ACK !== 1'b1) begin
            nMismatched++;
            $display("FAIL reset_ack_en1: got %b want 1", Core_ACK);
        end
        clk_en = 1'b0;
        #1;
        nCompared++;
        if (Core_ACK !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_ack_en0: got %b want 0", Core_ACK);
        end
        clk_en = 1'b1;
        tick();
    endtask

    task automatic test_single();
        // Flag without a pop must be ignored.
        Dev_RegResponseFlag = 1'b1;
        Dev_DestReg = 4'hA;
        Dev_Data = 16'hDEAD;
        tick();
        nCompared++;
        if (Resp_Valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL flag_no_pop: got Resp_Valid=%b want 0", Resp_Valid);
        end
        Dev_RegResponseFlag = 1'b0;
        Core_REQ = 1'b1;
        Core_ResponseRequested = 1'b1;
        Core_DestReg = 4'd5;
        Core_Data = 16'h2401;
        IO_ACK = 1'b1;
        #1;
        nCompared++;
        if (IO_REQ !== 1'b0) begin
            nMismatched++;
            $display("FAIL single_no_bypass: got IO_REQ=%b want 0", IO_REQ);
        end
        tick();
        Core_REQ = 1'b0;
        Dev_RegResponseFlag = 1'b1;
        Dev_DestReg = 4'd5;
        Dev_Data = 16'h0001;
        #1;
        nCompared++;
        if (IO_REQ !== 1'b1 || IO_DataOut !== 16'h2401 || IO_DestRegOut !== 4'd5 || IO_ResponseRequested !== 1'b1) begin
            nMismatched++;
            $display("FAIL single_head: got req=%b data=%h dest=%h rr=%b want 1 2401 5 1",
                     IO_REQ, IO_DataOut, IO_DestRegOut, IO_ResponseRequested);
        end
        nCompared++;
        if (Resp_Valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL single_resp_early: got %b want 0", Resp_Valid);
        end
        tick();
        Dev_RegResponseFlag = 1'b0;
        Dev_Data = 16'h7777;
        IO_ACK = 1'b0;
        nCompared++;
        if (Resp_Valid !== 1'b1 || Resp_DestReg !== 4'd5 || Resp_Data !== 16'h0001) begin
            nMismatched++;
            $display("FAIL single_resp: got %b %h %h want 1 5 0001", Resp_Valid, Resp_DestReg, Resp_Data);
        end
        nCompared++;
        if (IO_REQ !== 1'b0 || Occupancy !== 3'd0) begin
            nMismatched++;
            $display("FAIL single_empty: got req=%b occ=%0d want 0 0", IO_REQ, Occupancy);
        end
        tick();
        nCompared++;
        if (Resp_Valid !== 1'b0 || Resp_Data !== 16'h0001) begin
            nMismatched++;
            $display("FAIL single_pulse_end: got %b %h want 0 0001", Resp_Valid, Resp_Data);
        end
    endtask

    task automatic test_fill();
        IO_ACK = 1'b0;
        Core_ResponseRequested = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            Core_REQ = 1'b1;
            Core_DestReg = 4'(i);
            Core_Data = 16'h1000 + 16'(i);
            #1;
            nCompared++;
            if (Core_ACK !== (i <= 4)) begin
                nMismatched++;
                $display("FAIL fill_ack[%0d]: got %b want %b", i, Core_ACK, (i <= 4));
            end
            tick();
            nCompared++;
            if (Occupancy !== ((i <= 4) ? 3'(i) : 3'd4)) begin
                nMismatched++;
                $display("FAIL fill_occ[%0d]: got %0d want %0d", i, Occupancy, (i <= 4) ? i : 4);
            end
        end
        Core_REQ = 1'b0;
    endtask

    task automatic test_drain();
        IO_ACK = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            nCompared++;
            if (IO_REQ !== 1'b1 || IO_DataOut !== 16'h1000 + 16'(i) || IO_DestRegOut !== 4'(i)) begin
                nMismatched++;
                $display("FAIL drain[%0d]: got req=%b data=%h dest=%h want 1 %h %h",
                         i, IO_REQ, IO_DataOut, IO_DestRegOut, 16'h1000 + 16'(i), 4'(i));
            end
            tick();
        end
        nCompared++;
        if (IO_REQ !== 1'b0 || Occupancy !== 3'd0) begin
            nMismatched++;
            $display("FAIL drain_end: got req=%b occ=%0d want 0 0", IO_REQ, Occupancy);
        end
        IO_ACK = 1'b0;
    endtask

    task automatic test_back_to_back();
        IO_ACK = 1'b0;
        for (int k = 0; k < 3; k++) begin
            Core_REQ = 1'b1;
            Core_Data = 16'h2000 + 16'(k);
            tick();
        end
        nCompared++;
        if (Occupancy !== 3'd3) begin
            nMismatched++;
            $display("FAIL b2b_setup: got occ=%0d want 3", Occupancy);
        end
        IO_ACK = 1'b1;
        for (int c = 0; c < 10; c++) begin
            Core_REQ = 1'b1;
            Core_Data = 16'h2000 + 16'(c + 3);
            #1;
            nCompared++;
            if (IO_DataOut !== 16'h2000 + 16'(c) || Core_ACK !== 1'b1) begin
                nMismatched++;
                $display("FAIL b2b_head[%0d]: got data=%h ack=%b want %h 1",
                         c, IO_DataOut, Core_ACK, 16'h2000 + 16'(c));
            end
            tick();
            nCompared++;
            if (Occupancy !== 3'd3) begin
                nMismatched++;
                $display("FAIL b2b_occ[%0d]: got %0d want 3", c, Occupancy);
            end
        end
        Core_REQ = 1'b0;
        for (int c = 10; c < 13; c++) begin
            #1;
            nCompared++;
            if (IO_REQ !== 1'b1 || IO_DataOut !== 16'h2000 + 16'(c)) begin
                nMismatched++;
                $display("FAIL b2b_drain[%0d]: got req=%b data=%h want 1 %h",
                         c, IO_REQ, IO_DataOut, 16'h2000 + 16'(c));
            end
            tick();
        end
        nCompared++;
        if (IO_REQ !== 1'b0) begin
            nMismatched++;
            $display("FAIL b2b_empty: got req=%b want 0", IO_REQ);
        end
        IO_ACK = 1'b0;
    endtask

    task automatic test_stall();
        Core_REQ = 1'b1;
        Core_Data = 16'h3000;
        tick();
        Core_Data = 16'h3001;
        tick();
        Core_Data = 16'h3002;
        IO_ACK = 1'b1;
        Dev_RegResponseFlag = 1'b1;
        Dev_DestReg = 4'd9;
        Dev_Data = 16'hBEEF;
        tick();
        nCompared++;
        if (Occupancy !== 3'd2 || Resp_Valid !== 1'b1 || Resp_Data !== 16'hBEEF) begin
            nMismatched++;
            $display("FAIL stall_setup: got occ=%0d rv=%b rd=%h want 2 1 beef", Occupancy, Resp_Valid, Resp_Data);
        end
        clk_en = 1'b0;
        Core_Data = 16'h3003;
        Dev_DestReg = 4'd1;
        Dev_Data = 16'h1234;
        for (int s = 0; s < 3; s++) begin
            #1;
            nCompared++;
            if (Core_ACK !== 1'b0) begin
                nMismatched++;
                $display("FAIL stall_ack[%0d]: got %b want 0", s, Core_ACK);
            end
            tick();
            nCompared++;
            if (Occupancy !== 3'd2 || Resp_Valid !== 1'b1 || Resp_Data !== 16'hBEEF ||
                Resp_DestReg !== 4'd9 || IO_DataOut !== 16'h3001) begin
                nMismatched++;
                $display("FAIL stall_hold[%0d]: got occ=%0d rv=%b rd=%h rdst=%h head=%h want 2 1 beef 9 3001",
                         s, Occupancy, Resp_Valid, Resp_Data, Resp_DestReg, IO_DataOut);
            end
        end
        clk_en = 1'b1;
        Core_REQ = 1'b0;
        IO_ACK = 1'b0;
        Dev_RegResponseFlag = 1'b0;
        tick();
        nCompared++;
        if (Resp_Valid !== 1'b0 || Resp_Data !== 16'hBEEF || Occupancy !== 3'd2 || IO_DataOut !== 16'h3001) begin
            nMismatched++;
            $display("FAIL stall_resume: got rv=%b rd=%h occ=%0d head=%h want 0 beef 2 3001",
                     Resp_Valid, Resp_Data, Occupancy, IO_DataOut);
        end
    endtask

    task automatic test_reset_mid();
        Core_REQ = 1'b1;
        Core_Data = 16'h3003;
        IO_ACK = 1'b1;
        Dev_RegResponseFlag = 1'b1;
        Dev_DestReg = 4'd3;
        Dev_Data = 16'h5555;
        tick();
        nCompared++;
        if (Occupancy !== 3'd2 || Resp_Valid !== 1'b1) begin
            nMismatched++;
            $display("FAIL rstmid_setup: got occ=%0d rv=%b want 2 1", Occupancy, Resp_Valid);
        end
        // Reset with clk_en low and traffic still offered.
        sync_rst = 1'b1;
        clk_en = 1'b0;
        tick();
        sync_rst = 1'b0;
        idleInputs();
        #1;
        nCompared++;
        if (Occupancy !== 3'd0 || IO_REQ !== 1'b0 || Resp_Valid !== 1'b0 ||
            Resp_DestReg !== 4'h0 || Resp_Data !== 16'h0000) begin
            nMismatched++;
            $display("FAIL rstmid_clear: got occ=%0d req=%b rv=%b rdst=%h rd=%h want 0 0 0 0 0000",
                     Occupancy, IO_REQ, Resp_Valid, Resp_DestReg, Resp_Data);
        end
        clk_en = 1'b1;
        Core_REQ = 1'b1;
        Core_Data = 16'h4444;
        tick();
        Core_REQ = 1'b0;
        #1;
        nCompared++;
        if (Occupancy !== 3'd1 || IO_DataOut !== 16'h4444) begin
            nMismatched++;
            $display("FAIL rstmid_after: got occ=%0d head=%h want 1 4444", Occupancy, IO_DataOut);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
